// File: rtl/regfile_wr_ctrl_if.sv
// Write-request and register-array bus for regfile_wr_ctrl.
// master drives requests; slave is the controller driving EN/D and status.
interface regfile_wr_ctrl_if #(
  parameter int DW   = 4,
  parameter int NREG = 8,
  parameter int AW   = 3
) ();
  logic            WR_VALID;
  logic            WR_READY;
  logic [AW-1:0]   WR_ADDR;
  logic [DW-1:0]   WR_DATA;
  logic            CLR_REQ;
  logic [NREG-1:0] EN;
  logic [DW-1:0]   D;
  logic            BUSY;
  logic            ERR;

  modport master (
    output WR_VALID, WR_ADDR, WR_DATA, CLR_REQ,
    input  WR_READY, EN, D, BUSY, ERR
  );

  modport slave (
    input  WR_VALID, WR_ADDR, WR_DATA, CLR_REQ,
    output WR_READY, EN, D, BUSY, ERR
  );
endinterface

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller: 2-entry request FIFO, one-hot EN/D issue, sequenced clear.
// Optional macro REGFILE_REG0_ZERO_EN makes register 0 read-only zero.
module regfile_wr_ctrl #(
  parameter int DW    = 4,
  parameter int NREG  = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic           CLK,
  input  logic           RST,
  regfile_wr_ctrl_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, CLR_WAIT, CLR_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_mem [DEPTH];
  logic [DW-1:0]   data_mem [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            clr_pending_q, clr_pending_d;
  logic [NREG-1:0] en_q, en_d;
  logic [DW-1:0]   d_q, d_d;
  logic            err_q, err_d;
  logic            wr_ready, push, pop;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_addr = addr_mem[rptr_q];
  assign head_data = data_mem[rptr_q];
  assign wr_ready  = (count_q < CW'(DEPTH)) && (state_q == IDLE) && !clr_pending_q;
  assign push      = bus.WR_VALID && wr_ready;
  // The clear walk owns the EN bus, so the FIFO only drains outside CLR_RUN.
  assign pop       = (count_q != '0) && (state_q != CLR_RUN);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    clr_pending_d = clr_pending_q;
    wptr_d        = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d        = pop  ? ptr_inc(rptr_q) : rptr_q;
    count_d       = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    en_d          = '0;
    d_d           = d_q;
    err_d         = err_q;

    if (pop) begin
      if ({1'b0, head_addr} >= (AW + 1)'(NREG)) begin
        err_d = 1'b1;
`ifdef REGFILE_REG0_ZERO_EN
      end else if (head_addr != '0) begin
`else
      end else begin
`endif
        en_d[head_addr] = 1'b1;
        d_d             = head_data;
      end
    end

    case (state_q)
      IDLE: begin
        // Anything still queued after this edge (including a same-edge push) drains first.
        if (bus.CLR_REQ) begin
          if (count_d != '0) begin
            state_d       = CLR_WAIT;
            clr_pending_d = 1'b1;
          end else begin
            state_d   = CLR_RUN;
            clr_cnt_d = '0;
          end
        end
      end
      CLR_WAIT: begin
        if (count_d == '0) begin
          state_d   = CLR_RUN;
          clr_cnt_d = '0;
        end
      end
      CLR_RUN: begin
        en_d            = '0;
        en_d[clr_cnt_q] = 1'b1;
        d_d             = '0;
        if (clr_cnt_q == AW'(NREG - 1)) begin
          state_d       = IDLE;
          clr_cnt_d     = '0;
          clr_pending_d = 1'b0;
          err_d         = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      clr_cnt_q     <= '0;
      clr_pending_q <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      en_q          <= '0;
      d_q           <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      clr_pending_q <= clr_pending_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      en_q          <= en_d;
      d_q           <= d_d;
      err_q         <= err_d;
    end
  end

  // NOTE: FIFO storage has no reset; clearing count and pointers already discards it.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wptr_q] <= bus.WR_ADDR;
      data_mem[wptr_q] <= bus.WR_DATA;
    end
  end

  assign bus.WR_READY = wr_ready;
  assign bus.EN       = en_q;
  assign bus.D        = d_q;
  assign bus.BUSY     = (count_q != '0) || (state_q != IDLE);
  assign bus.ERR      = err_q;
endmodule

// File: doc/regfile_wr_ctrl.md
Name: regfile_wr_ctrl

Overview:
Write-port controller sitting directly upstream of the register array built from 4-bit enable-gated DFF registers.
- Accepts write requests over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Issues one write per cycle as a registered one-hot enable vector plus a shared data bus that feed the register EN and D inputs.
- Also runs a sequenced clear of every register on request.

Parameters:
DW, 4, data width of each register and of WR_DATA/D
NREG, 8, number of registers driven; width of EN
AW, 3, address width; must satisfy 2^AW >= NREG
DEPTH, 2, request FIFO depth in entries

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
WR_VALID  input  1  write request valid
WR_READY  output  1  controller can accept a request this cycle
WR_ADDR  input  AW  target register index
WR_DATA  input  DW  write data
CLR_REQ  input  1  single-cycle pulse requesting clear of all registers
EN  output  NREG  registered one-hot write enable to the register array
D  output  DW  registered write data to the register array
BUSY  output  1  FIFO non-empty or state not IDLE
ERR  output  1  sticky flag: out-of-range address received

Behaviour:
- Reset (RST=0, asynchronous):
  - EN=0, D=0, ERR=0.
  - FIFO count=0, read/write pointers=0.
  - State=IDLE, clear counter=0.
  - WR_READY=1 once reset deasserts.
- Handshake:
  - A request is accepted on a rising edge when WR_VALID & WR_READY.
  - WR_READY = (count < DEPTH) & (state == IDLE) & ~clr_pending.
  - WR_ADDR/WR_DATA are ignored when not accepted.
- FIFO:
  - Circular buffer, DEPTH entries of {addr,data}; pointers wrap modulo DEPTH.
  - Push and pop on the same edge leave count unchanged.
- States:
  - IDLE:
    - If count>0, pop the head on each edge.
    - Register EN = onehot(addr) and D = data.
    - Otherwise EN=0; D holds its last value.
    - On CLR_REQ with count>0, set clr_pending and go to CLR_WAIT.
    - On CLR_REQ with count==0, go directly to CLR_RUN with counter=0.
  - CLR_WAIT: continue draining the FIFO as in IDLE. On the edge that pops the last entry, go to CLR_RUN with counter=0.
  - CLR_RUN:
    - Each edge registers EN = onehot(counter) and D = 0, then increments counter.
    - After issuing counter = NREG-1, return to IDLE and clear clr_pending and ERR.
- Timing:
  - Clear occupies exactly NREG cycles of EN activity.
  - CLR_REQ while in CLR_WAIT or CLR_RUN is ignored.
- Latency:
  - Request accepted at edge k is popped at edge k+1 (EN/D valid after k+1).
  - The register captures it at edge k+2.
  - Sustained throughput is 1 write/cycle, with WR_VALID held high and the FIFO never exceeding 1 entry.
- EN is always one-hot or zero, never multi-hot.
- Out-of-range (addr >= NREG):
  - The entry is popped normally, but EN=0 that cycle and D is unchanged.
  - ERR is set on that edge and stays set until reset or completion of a clear.
- Simultaneous events:
  - CLR_REQ on the same edge as an accepted request: the request is enqueued and drained before the clear starts.
- Reset mid-operation (including mid-clear) aborts immediately:
  - EN is forced to 0 at once (asynchronous).
  - FIFO contents are discarded.
- BUSY = (count != 0) | (state != IDLE).

Optional Feature:
Macro REGFILE_REG0_ZERO_EN.
- Defined: register 0 is read-only zero.
  - Writes to address 0 are popped and dropped: EN=0 that cycle, ERR unaffected.
  - CLR_RUN still asserts EN[0] with D=0.
- Undefined: address 0 is an ordinary writable register.

Test Plan:
- Reset with RST=0 mid-stream, then release: EN=0, D=0, ERR=0, BUSY=0, WR_READY=1 on the first cycle after release.
- Single write addr=5 data=4'hA accepted at edge k: EN=8'b0010_0000 and D=4'hA after edge k+1; EN=0 after edge k+2.
- Back-to-back writes (1,4'h3), (2,4'h6), (7,4'hF) on consecutive cycles:
  - EN sequence 0x02, 0x04, 0x80 on consecutive cycles.
  - WR_READY stays 1 throughout.
- Write addr=6 with CLR_REQ pulsed on the same edge:
  - EN=0x40 with D=4'h6 first.
  - Then EN walks 0x01..0x80 over 8 cycles with D=0.
  - WR_READY=0 until IDLE returns; BUSY=0 afterwards.
- NREG=6 with write addr=7: EN stays 0 and ERR=1; ERR clears after a full CLR_REQ sequence.
- Assert RST at the 3rd cycle of CLR_RUN: EN=0 immediately; after release state=IDLE, WR_READY=1, no further EN pulses.
